// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types and defaults for the execute-stage writeback merger.
package fu_wb_arbiter_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned TRANS_ID_BITS  = 3;
  localparam int unsigned NR_FU_CHANNELS = 4;
  localparam int unsigned NR_WB_PORTS    = 2;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  // One buffered functional-unit result.
  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    exception_t               exception;
  } wb_entry_t;

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// Producer-channel and scoreboard write-port bundle.
interface fu_wb_arbiter_if
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrChannels = NR_FU_CHANNELS,
  parameter int unsigned NrWbPorts  = NR_WB_PORTS
);

  logic       [NrChannels-1:0]                    ch_valid_i;
  logic       [NrChannels-1:0]                    ch_ready_o;
  logic       [NrChannels-1:0][TRANS_ID_BITS-1:0] ch_trans_id_i;
  logic       [NrChannels-1:0][XLEN-1:0]          ch_result_i;
  exception_t [NrChannels-1:0]                    ch_exception_i;

  logic       [NrWbPorts-1:0]                     wb_valid_o;
  logic       [NrWbPorts-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_o;
  logic       [NrWbPorts-1:0][XLEN-1:0]           wb_result_o;
  exception_t [NrWbPorts-1:0]                     wb_exception_o;

  // Functional units and scoreboard side
  modport master (
    output ch_valid_i, ch_trans_id_i, ch_result_i, ch_exception_i,
    input  ch_ready_o,
    input  wb_valid_o, wb_trans_id_o, wb_result_o, wb_exception_o
  );

  // Arbiter side
  modport slave (
    input  ch_valid_i, ch_trans_id_i, ch_result_i, ch_exception_i,
    output ch_ready_o,
    output wb_valid_o, wb_trans_id_o, wb_result_o, wb_exception_o
  );

endinterface

// File: rtl/fu_wb_fifo.sv
// Single-channel result FIFO with flush; no pass-through when full.
module fu_wb_fifo
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  wb_entry_t data_i,
  input  logic      pop_i,
  output wb_entry_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  wb_entry_t       mem_q [Depth];

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; flush clears everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    if (push_i && !pop_i) cnt_d = cnt_q + CntW'(1);
    if (!push_i && pop_i) cnt_d = cnt_q - CntW'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while unoccupied
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/fu_wb_arbiter.sv
// Merges N buffered functional-unit result channels onto M scoreboard write ports.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrChannels = NR_FU_CHANNELS,
  parameter int unsigned NrWbPorts  = NR_WB_PORTS,
  parameter int unsigned FifoDepth  = 2,
  parameter int unsigned RoundRobin = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  fu_wb_arbiter_if.slave bus,
  output logic           busy_o
);

  localparam int unsigned ChW   = (NrChannels > 1) ? $clog2(NrChannels) : 1;
  localparam int unsigned PortW = (NrWbPorts > 1) ? $clog2(NrWbPorts) : 1;

  if (NrChannels < 1) begin : g_bad_ch
    $error("NrChannels must be >= 1");
  end
  if (NrWbPorts < 1 || NrWbPorts > NrChannels) begin : g_bad_ports
    $error("NrWbPorts must be in 1..NrChannels");
  end
  if (FifoDepth < 1) begin : g_bad_depth
    $error("FifoDepth must be >= 1");
  end
  if (RoundRobin > 1) begin : g_bad_rr
    $error("RoundRobin must be 0 or 1");
  end

  logic [NrChannels-1:0] push, pop, full, empty, ch_ready;
  wb_entry_t             ch_entry [NrChannels];
  wb_entry_t             head     [NrChannels];
  wb_entry_t             wb_sel   [NrWbPorts];
  logic [NrWbPorts-1:0]  wb_valid;

  logic            arb_en;
  logic [ChW-1:0]  rr_ptr_q, rr_ptr_d, start, last_grant;
  logic [ChW:0]    scan_idx, rr_next;
  logic [PortW:0]  n_grant;
  logic            any_grant;

  assign arb_en          = ~rst_i & ~flush_i;
  assign ch_ready        = ~full & {NrChannels{arb_en}};
  assign bus.ch_ready_o  = ch_ready;
  assign push            = bus.ch_valid_i & ch_ready;
  assign busy_o          = ~rst_i & ~(&empty);
  assign start           = (RoundRobin != 0) ? rr_ptr_q : '0;

  for (genvar c = 0; c < NrChannels; c++) begin : g_ch
    assign ch_entry[c] = '{trans_id:  bus.ch_trans_id_i[c],
                           result:    bus.ch_result_i[c],
                           exception: bus.ch_exception_i[c]};

    fu_wb_fifo #(
      .Depth (FifoDepth)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push[c]),
      .data_i  (ch_entry[c]),
      .pop_i   (pop[c]),
      .data_o  (head[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );
  end

  // Scan channels from the priority start, granting the first NrWbPorts non-empty ones
  always_comb begin
    pop        = '0;
    wb_valid   = '0;
    for (int unsigned p = 0; p < NrWbPorts; p++) wb_sel[p] = '0;
    last_grant = '0;
    any_grant  = 1'b0;
    n_grant    = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NrChannels; i++) begin
      scan_idx = {1'b0, start} + (ChW+1)'(i);
      if (scan_idx >= (ChW+1)'(NrChannels)) scan_idx = scan_idx - (ChW+1)'(NrChannels);
      if (arb_en && !empty[scan_idx[ChW-1:0]] && (n_grant < (PortW+1)'(NrWbPorts))) begin
        pop[scan_idx[ChW-1:0]]     = 1'b1;
        wb_valid[n_grant[PortW-1:0]] = 1'b1;
        wb_sel[n_grant[PortW-1:0]]   = head[scan_idx[ChW-1:0]];
        last_grant                 = scan_idx[ChW-1:0];
        any_grant                  = 1'b1;
        n_grant                    = n_grant + (PortW+1)'(1);
      end
    end
    rr_next = {1'b0, last_grant} + (ChW+1)'(1);
    if (rr_next == (ChW+1)'(NrChannels)) rr_next = '0;
    rr_ptr_d = ((RoundRobin != 0) && any_grant) ? rr_next[ChW-1:0] : rr_ptr_q;
  end

  // Rotating-priority pointer; survives flush, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign bus.wb_valid_o = wb_valid;
  for (genvar p = 0; p < NrWbPorts; p++) begin : g_port
    assign bus.wb_trans_id_o[p]  = wb_sel[p].trans_id;
    assign bus.wb_result_o[p]    = wb_sel[p].result;
    assign bus.wb_exception_o[p] = wb_sel[p].exception;

    for (genvar q = p + 1; q < NrWbPorts; q++) begin : g_pair
      a_uniq_id: assert property (@(posedge clk_i) disable iff (rst_i)
        !(wb_valid[p] && wb_valid[q] && (wb_sel[p].trans_id == wb_sel[q].trans_id)));
    end
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench: rotating, fixed 2-port and fixed 1-port arbiters driven in lockstep.
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst, flush;
  logic busy_rr, busy_fp, busy_fp1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fu_wb_arbiter_if #(.NrChannels(4), .NrWbPorts(2)) if_rr  ();
  fu_wb_arbiter_if #(.NrChannels(4), .NrWbPorts(2)) if_fp  ();
  fu_wb_arbiter_if #(.NrChannels(4), .NrWbPorts(1)) if_fp1 ();

  fu_wb_arbiter #(.NrChannels(4), .NrWbPorts(2), .FifoDepth(2), .RoundRobin(1)) u_rr (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_rr), .busy_o(busy_rr));
  fu_wb_arbiter #(.NrChannels(4), .NrWbPorts(2), .FifoDepth(2), .RoundRobin(0)) u_fp (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_fp), .busy_o(busy_fp));
  fu_wb_arbiter #(.NrChannels(4), .NrWbPorts(1), .FifoDepth(2), .RoundRobin(0)) u_fp1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_fp1), .busy_o(busy_fp1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_rr.ch_valid_i  = '0; if_rr.ch_trans_id_i  = '0; if_rr.ch_result_i  = '0; if_rr.ch_exception_i  = '0;
    if_fp.ch_valid_i  = '0; if_fp.ch_trans_id_i  = '0; if_fp.ch_result_i  = '0; if_fp.ch_exception_i  = '0;
    if_fp1.ch_valid_i = '0; if_fp1.ch_trans_id_i = '0; if_fp1.ch_result_i = '0; if_fp1.ch_exception_i = '0;
  endtask

  task automatic put(input logic [1:0] c, input logic [2:0] id, input logic [31:0] res);
    exception_t ex;
    ex = '{cause: 32'(id), tval: res, valid: 1'b1};
    if_rr.ch_valid_i[c]  = 1'b1; if_rr.ch_trans_id_i[c]  = id; if_rr.ch_result_i[c]  = res; if_rr.ch_exception_i[c]  = ex;
    if_fp.ch_valid_i[c]  = 1'b1; if_fp.ch_trans_id_i[c]  = id; if_fp.ch_result_i[c]  = res; if_fp.ch_exception_i[c]  = ex;
    if_fp1.ch_valid_i[c] = 1'b1; if_fp1.ch_trans_id_i[c] = id; if_fp1.ch_result_i[c] = res; if_fp1.ch_exception_i[c] = ex;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; idle();
    tick(); tick();
    chk("rst_ready_rr", 64'(if_rr.ch_ready_o), 64'h0);
    chk("rst_valid_rr", 64'(if_rr.wb_valid_o), 64'h0);
    chk("rst_busy_rr",  64'(busy_rr), 64'h0);
    chk("rst_valid_fp", 64'(if_fp.wb_valid_o), 64'h0);
    rst = 1'b0; #1;
    chk("post_rst_ready_rr", 64'(if_rr.ch_ready_o), 64'hF);
    chk("post_rst_ready_fp", 64'(if_fp.ch_ready_o), 64'hF);
    chk("post_rst_rrptr",    64'(u_rr.rr_ptr_q), 64'h0);

    // single result, one-cycle latency
    put(2'd0, 3'd3, 32'hA5); #1;
    chk("basic_nobypass", 64'(if_rr.wb_valid_o), 64'h0);
    tick(); idle(); #1;
    chk("basic_valid_rr", 64'(if_rr.wb_valid_o), 64'h1);
    chk("basic_id_rr",    64'(if_rr.wb_trans_id_o[0]), 64'h3);
    chk("basic_res_rr",   64'(if_rr.wb_result_o[0]), 64'hA5);
    chk("basic_res1_rr",  64'(if_rr.wb_result_o[1]), 64'h0);
    chk("basic_exc_rr",   64'(if_rr.wb_exception_o[0].valid), 64'h1);
    chk("basic_busy_rr",  64'(busy_rr), 64'h1);
    chk("basic_valid_fp", 64'(if_fp.wb_valid_o), 64'h1);
    chk("basic_id_fp",    64'(if_fp.wb_trans_id_o[0]), 64'h3);
    tick(); #1;
    chk("basic_idle_rr",  64'(if_rr.wb_valid_o), 64'h0);
    chk("basic_busy0_rr", 64'(busy_rr), 64'h0);
    chk("basic_busy0_fp", 64'(busy_fp), 64'h0);

    // collision: four channels at once onto two ports
    do_reset();
    for (int c = 0; c < 4; c++) put(2'(c), 3'(c), 32'h100 + 32'(c));
    #1; tick(); idle(); #1;
    chk("coll1_valid_rr", 64'(if_rr.wb_valid_o), 64'h3);
    chk("coll1_id0_rr",   64'(if_rr.wb_trans_id_o[0]), 64'h0);
    chk("coll1_id1_rr",   64'(if_rr.wb_trans_id_o[1]), 64'h1);
    chk("coll1_res1_rr",  64'(if_rr.wb_result_o[1]), 64'h101);
    chk("coll1_id1_fp",   64'(if_fp.wb_trans_id_o[1]), 64'h1);
    tick(); #1;
    chk("coll2_id0_rr",   64'(if_rr.wb_trans_id_o[0]), 64'h2);
    chk("coll2_id1_rr",   64'(if_rr.wb_trans_id_o[1]), 64'h3);
    chk("coll2_rrptr",    64'(u_rr.rr_ptr_q), 64'h2);
    chk("coll2_id0_fp",   64'(if_fp.wb_trans_id_o[0]), 64'h2);
    chk("coll2_id1_fp",   64'(if_fp.wb_trans_id_o[1]), 64'h3);
    tick(); #1;
    chk("coll3_rrptr_wrap", 64'(u_rr.rr_ptr_q), 64'h0);
    chk("coll3_busy_rr",    64'(busy_rr), 64'h0);

    // fixed priority: ch0 streams, ch3 pushes once
    do_reset();
    for (int k = 0; k < 8; k++) begin
      idle();
      if (k < 6) put(2'd0, 3'(k + 1), 32'h10 + 32'(k));
      if (k == 0) put(2'd3, 3'd7, 32'h70);
      #1;
      if (k >= 1 && k <= 6) begin
        chk("fp1_stream_valid", 64'(if_fp1.wb_valid_o), 64'h1);
        chk("fp1_stream_id",    64'(if_fp1.wb_trans_id_o[0]), 64'(k));
      end
      if (k == 1) begin
        chk("fp_ch3_valid", 64'(if_fp.wb_valid_o), 64'h3);
        chk("fp_ch3_port1", 64'(if_fp.wb_trans_id_o[1]), 64'h7);
        chk("rr_ch3_port1", 64'(if_rr.wb_trans_id_o[1]), 64'h7);
      end
      if (k == 2) chk("fp_ch3_gone", 64'(if_fp.wb_valid_o), 64'h1);
      if (k == 7) begin
        chk("fp1_ch3_late_id",  64'(if_fp1.wb_trans_id_o[0]), 64'h7);
        chk("fp1_ch3_late_res", 64'(if_fp1.wb_result_o[0]), 64'h70);
      end
      tick();
    end

    // full FIFO refuses even when popped in the same cycle
    do_reset();
    put(2'd0, 3'd4, 32'h40); put(2'd1, 3'd5, 32'h50); #1; tick();
    idle(); put(2'd1, 3'd1, 32'h11); put(2'd2, 3'd2, 32'h22); put(2'd3, 3'd3, 32'h33); #1;
    chk("full_c1_id0_rr", 64'(if_rr.wb_trans_id_o[0]), 64'h4);
    chk("full_c1_id1_rr", 64'(if_rr.wb_trans_id_o[1]), 64'h5);
    chk("full_c1_id_fp1", 64'(if_fp1.wb_trans_id_o[0]), 64'h4);
    tick(); idle(); put(2'd1, 3'd6, 32'h66); #1;
    chk("full_c2_id0_rr",   64'(if_rr.wb_trans_id_o[0]), 64'h2);
    chk("full_c2_id1_rr",   64'(if_rr.wb_trans_id_o[1]), 64'h3);
    chk("full_c2_rdy1_rr",  64'(if_rr.ch_ready_o[1]), 64'h1);
    chk("full_c2_id0_fp",   64'(if_fp.wb_trans_id_o[0]), 64'h1);
    chk("full_c2_id1_fp",   64'(if_fp.wb_trans_id_o[1]), 64'h2);
    chk("full_c2_rdy1_fp1", 64'(if_fp1.ch_ready_o[1]), 64'h0);
    chk("full_c2_id_fp1",   64'(if_fp1.wb_trans_id_o[0]), 64'h5);
    tick(); idle(); put(2'd1, 3'd7, 32'h77); #1;
    chk("full_c3_rdy1_rr",  64'(if_rr.ch_ready_o[1]), 64'h0);
    chk("full_c3_valid_rr", 64'(if_rr.wb_valid_o), 64'h1);
    chk("full_c3_id0_rr",   64'(if_rr.wb_trans_id_o[0]), 64'h1);
    chk("full_c3_rdy1_fp",  64'(if_fp.ch_ready_o[1]), 64'h1);
    chk("full_c3_id0_fp",   64'(if_fp.wb_trans_id_o[0]), 64'h6);
    chk("full_c3_id1_fp",   64'(if_fp.wb_trans_id_o[1]), 64'h3);
    chk("full_c3_id_fp1",   64'(if_fp1.wb_trans_id_o[0]), 64'h1);
    tick(); idle(); put(2'd1, 3'd7, 32'h77); #1;
    chk("full_c4_rdy1_rr",  64'(if_rr.ch_ready_o[1]), 64'h1);
    chk("full_c4_valid_rr", 64'(if_rr.wb_valid_o), 64'h1);
    chk("full_c4_id0_rr",   64'(if_rr.wb_trans_id_o[0]), 64'h6);
    tick(); idle(); #1;
    chk("full_c5_id0_rr",   64'(if_rr.wb_trans_id_o[0]), 64'h7);
    chk("full_c5_res0_rr",  64'(if_rr.wb_result_o[0]), 64'h77);
    chk("full_c5_valid_rr", 64'(if_rr.wb_valid_o), 64'h1);
    tick(); #1;
    chk("full_c6_busy_rr",  64'(busy_rr), 64'h0);

    // flush with buffered entries and a simultaneous push
    do_reset();
    for (int c = 0; c < 4; c++) put(2'(c), 3'(c), 32'h200 + 32'(c));
    #1; tick();
    idle(); put(2'd0, 3'd4, 32'h204); put(2'd2, 3'd6, 32'h206); put(2'd3, 3'd7, 32'h207); #1;
    tick(); idle(); flush = 1'b1; put(2'd2, 3'd1, 32'h999); #1;
    chk("flush_valid_rr", 64'(if_rr.wb_valid_o), 64'h0);
    chk("flush_valid_fp", 64'(if_fp.wb_valid_o), 64'h0);
    chk("flush_ready_rr", 64'(if_rr.ch_ready_o), 64'h0);
    chk("flush_busy_rr",  64'(busy_rr), 64'h1);
    tick(); flush = 1'b0; idle(); #1;
    chk("flush1_valid_rr", 64'(if_rr.wb_valid_o), 64'h0);
    chk("flush1_valid_fp", 64'(if_fp.wb_valid_o), 64'h0);
    chk("flush1_busy_rr",  64'(busy_rr), 64'h0);
    chk("flush1_busy_fp",  64'(busy_fp), 64'h0);
    chk("flush1_rrptr",    64'(u_rr.rr_ptr_q), 64'h2);
    tick(); #1;
    chk("flush2_valid_rr", 64'(if_rr.wb_valid_o), 64'h0);
    chk("flush2_busy_rr",  64'(busy_rr), 64'h0);

    // reset mid-operation with rr_ptr = 2
    tick(); put(2'd0, 3'd5, 32'h55); put(2'd3, 3'd6, 32'h66); #1;
    tick(); idle(); rst = 1'b1; #1;
    chk("midrst_valid_rr", 64'(if_rr.wb_valid_o), 64'h0);
    chk("midrst_busy_rr",  64'(busy_rr), 64'h0);
    chk("midrst_ready_rr", 64'(if_rr.ch_ready_o), 64'h0);
    chk("midrst_rrptr_pre", 64'(u_rr.rr_ptr_q), 64'h2);
    tick(); rst = 1'b0; put(2'd0, 3'd1, 32'h11); put(2'd3, 3'd2, 32'h22); #1;
    chk("midrst1_valid_rr", 64'(if_rr.wb_valid_o), 64'h0);
    chk("midrst1_busy_rr",  64'(busy_rr), 64'h0);
    chk("midrst1_rrptr",    64'(u_rr.rr_ptr_q), 64'h0);
    chk("midrst1_ready_rr", 64'(if_rr.ch_ready_o), 64'hF);
    tick(); idle(); #1;
    chk("midrst2_valid_rr", 64'(if_rr.wb_valid_o), 64'h3);
    chk("midrst2_id0_rr",   64'(if_rr.wb_trans_id_o[0]), 64'h1);
    chk("midrst2_id1_rr",   64'(if_rr.wb_trans_id_o[1]), 64'h2);
    chk("midrst2_id0_fp",   64'(if_fp.wb_trans_id_o[0]), 64'h1);
    chk("midrst2_id1_fp",   64'(if_fp.wb_trans_id_o[1]), 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
